// File: rtl/quiz_pkg.sv
// quiz_pkg: shared types and constants for the quiz round controller.
//   state_t   - controller FSM states
//   OP_*      - operator codes shown on the display
//   LFSR_TAPS - feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   eval_draw - decodes one LFSR sample into a candidate equation
package quiz_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SHOW,
        S_CHECK,
        S_FEEDBACK,
        S_DONE
    } state_t;

    localparam logic [2:0]  OP_ADD = 3'd0;
    localparam logic [2:0]  OP_SUB = 3'd1;
    localparam logic [2:0]  OP_MUL = 3'd2;
    localparam logic [2:0]  OP_DIV = 3'd3;
    localparam logic [2:0]  OP_EQ  = 3'd5;

    // Bits 15,13,12,10 of the shift register are XORed into bit 0.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic       ok;
        logic [2:0] op;
        logic [9:0] n1;
        logic [9:0] n2;
        logic [6:0] ans;
    } draw_t;

    // One draw per LFSR sample; ok=0 means the sample is rejected and GEN
    // simply tries again on the next cycle.
    function automatic draw_t eval_draw(input logic [15:0] q);
        draw_t      d;
        logic [7:0] sum;
        logic [6:0] a7;
        logic [6:0] b7;
        logic [3:0] a4;
        logic [3:0] b4;
        a7  = q[8:2];
        b7  = q[15:9];
        a4  = q[5:2];
        b4  = q[9:6];
        sum = {1'b0, a7} + {1'b0, b7};
        d   = '0;
        case (q[1:0])
            2'd0: begin
                d.ok  = (sum <= 8'd99);
                d.op  = OP_ADD;
                d.n1  = {3'b0, a7};
                d.n2  = {3'b0, b7};
                d.ans = sum[6:0];
            end
            2'd1: begin
                d.ok  = (a7 <= 7'd99) && (b7 <= a7);
                d.op  = OP_SUB;
                d.n1  = {3'b0, a7};
                d.n2  = {3'b0, b7};
                d.ans = a7 - b7;
            end
            2'd2: begin
                d.ok  = (a4 <= 4'd9) && (b4 <= 4'd9);
                d.op  = OP_MUL;
                d.n1  = {6'b0, a4};
                d.n2  = {6'b0, b4};
                d.ans = {3'b0, a4} * {3'b0, b4};
            end
            default: begin
                // Divide is built backwards from divisor and quotient so it
                // never leaves a remainder.
                d.ok  = (a4 != 4'd0) && (a4 <= 4'd9) && (b4 <= 4'd9);
                d.op  = OP_DIV;
                d.n1  = {6'b0, a4} * {6'b0, b4};
                d.n2  = {6'b0, a4};
                d.ans = {3'b0, b4};
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: free-running 16-bit Fibonacci LFSR, advances every clock.
//   clk   - clock
//   reset - async active-high, loads SEED
//   q     - current register value
module lfsr16
    import quiz_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    logic [15:0] r_q;
    logic        w_fb;

    assign w_fb = ^(r_q & LFSR_TAPS);
    assign q    = r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_q <= SEED;
        else       r_q <= {r_q[14:0], w_fb};
    end

endmodule

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: arithmetic quiz game controller.
//   start/frame_tick/digit_valid/digit/enter - game and keypad inputs
//   num1/num2/operator  - equation on display
//   entry/entry_cnt     - typed answer and digit count
//   time_left/score/round_idx - game status
//   correct_pulse/wrong_pulse - one-cycle verdicts; busy/game_over - status
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int          NUM_ROUNDS = 10,
    parameter int          TIME_LIMIT = 600,
    parameter int          FB_FRAMES  = 60,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       frame_tick,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       enter,
    output logic [9:0] num1,
    output logic [9:0] num2,
    output logic [2:0] operator,
    output logic [9:0] entry,
    output logic [1:0] entry_cnt,
    output logic [9:0] time_left,
    output logic [3:0] score,
    output logic [3:0] round_idx,
    output logic       correct_pulse,
    output logic       wrong_pulse,
    output logic       busy,
    output logic       game_over
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [9:0] TL_LOAD    = 10'(TIME_LIMIT);
    localparam logic [9:0] FB_LAST    = 10'(FB_FRAMES - 1);

    state_t      r_state, w_next;
    logic [9:0]  r_num1, r_num2, r_entry, r_tl, r_fb;
    logic [2:0]  r_op;
    logic [6:0]  r_ans;
    logic [1:0]  r_cnt;
    logic [3:0]  r_score, r_round;
    logic        r_to;
    logic [15:0] w_lfsr;
    draw_t       w_draw;
    logic        w_enter_ok, w_digit_ok, w_timeout, w_match, w_fb_done;

    lfsr16 #(.SEED(SEED)) u_lfsr (.clk(clk), .reset(reset), .q(w_lfsr));

    assign w_draw     = eval_draw(w_lfsr);
    assign w_enter_ok = (r_state == S_SHOW) && enter && (r_cnt != 2'd0);
    // Any enter drops a same-cycle digit, even one that is itself ignored.
    assign w_digit_ok = (r_state == S_SHOW) && digit_valid && !enter &&
                        (r_cnt < 2'd2) && (digit <= 4'd9);
    // An accepted enter wins over the tick that would expire the timer.
    assign w_timeout  = (r_state == S_SHOW) && frame_tick && !w_enter_ok &&
                        (r_tl == 10'd1);
    assign w_match    = (r_entry == {3'b0, r_ans});
    assign w_fb_done  = (r_state == S_FEEDBACK) && frame_tick && (r_fb == FB_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (start) w_next = S_GEN;
            S_GEN:      if (w_draw.ok) w_next = S_SHOW;
            S_SHOW:     if (w_enter_ok) w_next = S_CHECK;
                        else if (w_timeout) w_next = S_FEEDBACK;
            S_CHECK:    w_next = S_FEEDBACK;
            S_FEEDBACK: if (w_fb_done) w_next = (r_round == LAST_ROUND) ? S_DONE : S_GEN;
            S_DONE:     if (start) w_next = S_GEN;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy          = (r_state != S_IDLE) && (r_state != S_DONE);
        game_over     = (r_state == S_DONE);
        correct_pulse = (r_state == S_CHECK) && w_match;
        // Timeout verdict is registered so it lines up with FEEDBACK entry.
        wrong_pulse   = ((r_state == S_CHECK) && !w_match) || r_to;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_num1  <= '0;
            r_num2  <= '0;
            r_op    <= '0;
            r_ans   <= '0;
            r_entry <= '0;
            r_cnt   <= '0;
            r_tl    <= '0;
            r_score <= '0;
            r_round <= '0;
            r_fb    <= '0;
            r_to    <= 1'b0;
        end else begin
            r_to <= w_timeout;
            if (((r_state == S_IDLE) || (r_state == S_DONE)) && start) begin
                r_score <= '0;
                r_round <= '0;
            end
            if ((r_state == S_GEN) && w_draw.ok) begin
                r_num1  <= w_draw.n1;
                r_num2  <= w_draw.n2;
                r_op    <= w_draw.op;
                r_ans   <= w_draw.ans;
                r_entry <= '0;
                r_cnt   <= '0;
                r_tl    <= TL_LOAD;
            end
            if (w_digit_ok) begin
                r_entry <= r_entry * 10'd10 + {6'b0, digit};
                r_cnt   <= r_cnt + 2'd1;
            end
            if ((r_state == S_SHOW) && frame_tick && !w_enter_ok)
                r_tl <= r_tl - 10'd1;
            // A timed-out question still uses up its round.
            if (w_timeout)
                r_round <= r_round + 4'd1;
            if (r_state == S_CHECK) begin
                if (w_match) r_score <= r_score + 4'd1;
                r_round <= r_round + 4'd1;
            end
            if (r_state != S_FEEDBACK) r_fb <= '0;
            else if (frame_tick)       r_fb <= r_fb + 10'd1;
        end
    end

    assign num1      = r_num1;
    assign num2      = r_num2;
    assign operator  = r_op;
    assign entry     = r_entry;
    assign entry_cnt = r_cnt;
    assign time_left = r_tl;
    assign score     = r_score;
    assign round_idx = r_round;

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning rounds per game (1..15).
REQ-002 SHALL have parameter TIME_LIMIT, default 600, meaning frame_ticks allowed per answer (1..1023).
REQ-003 SHALL have parameter FB_FRAMES, default 60, meaning frame_ticks spent in feedback after each answer.
REQ-004 SHALL have parameter SEED, default 16'hACE1, meaning LFSR reset value (nonzero).
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to begin a game.
REQ-008 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per VGA frame.
REQ-009 SHALL have ports digit_valid (input, 1 bit) and digit (input, 4 bits): keypad digit strobe and value (0..9).
REQ-010 SHALL have port enter, input, 1 bit: submit entered answer.
REQ-011 SHALL have ports num1 and num2 (output, 10 bits each) and operator (output, 3 bits): equation shown to the display.
REQ-012 SHALL have ports entry (output, 10 bits) and entry_cnt (output, 2 bits): typed answer and its digit count.
REQ-013 SHALL have ports time_left (output, 10 bits), score (output, 4 bits) and round_idx (output, 4 bits).
REQ-014 SHALL have ports correct_pulse and wrong_pulse (output, 1 bit each), busy (output, 1 bit) and game_over (output, 1 bit).

Function
REQ-015 SHALL implement states IDLE, GEN, SHOW, CHECK, FEEDBACK and DONE.
REQ-016 SHALL leave IDLE for GEN on start, clear score and round_idx, and ignore start in every other state except DONE.
REQ-017 SHALL advance the 16-bit Fibonacci LFSR (taps 16,14,13,11) every cycle in all states.
REQ-018 SHALL, in GEN, evaluate one draw per cycle with op = lfsr[1:0] (0 '+', 1 '-', 2 'x', 3 '/') and stay in GEN until a draw is accepted.
REQ-019 SHALL accept '+' when a = lfsr[8:2] and b = lfsr[15:9] satisfy a+b<=99, and SHALL accept '-' when a<=99 and b<=a.
REQ-020 SHALL, for 'x', use a = lfsr[5:2] and b = lfsr[9:6], and accept only when both are <=9.
REQ-021 SHALL, for '/', use b = lfsr[5:2] and q = lfsr[9:6], accept only when 1<=b<=9 and q<=9, and output num1 = b*q and num2 = b.
REQ-022 SHALL, on acceptance, register num1, num2, operator and the internal expected answer, clear entry, load time_left = TIME_LIMIT, and enter SHOW.
REQ-023 SHALL, in SHOW, on digit_valid with entry_cnt<2, set entry = entry*10 + digit and increment entry_cnt; a third digit or a digit >9 SHALL be ignored.
REQ-024 SHALL, in SHOW, go to CHECK on enter when entry_cnt>0; enter with entry_cnt==0 SHALL be ignored.
REQ-025 SHALL, when enter and digit_valid occur in the same cycle, take enter and drop the digit.
REQ-026 SHALL decrement time_left on each frame_tick in SHOW; the tick that reaches 0 SHALL go to FEEDBACK with a one-cycle wrong_pulse.
REQ-027 SHALL, when enter and the final tick coincide, evaluate enter and leave time_left unchanged.
REQ-028 SHALL, in CHECK (one cycle), assert correct_pulse and increment score when entry equals the expected answer, assert wrong_pulse otherwise, increment round_idx, and enter FEEDBACK.
REQ-029 SHALL hold in FEEDBACK for FB_FRAMES frame_ticks, then enter DONE if round_idx==NUM_ROUNDS, else GEN.
REQ-030 SHALL, in DONE, assert game_over and go to GEN on start, clearing score and round_idx.
REQ-031 SHALL assert busy in every state except IDLE and DONE.
REQ-032 SHALL hold num1, num2 and operator stable from GEN exit until the next GEN acceptance.

Reset
REQ-033 SHALL, on reset at any time (including mid-round), set the state to IDLE, all outputs and counters to 0, and the LFSR to SEED.

Structure
REQ-034 SHALL declare the state enum, operator codes OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3 and OP_EQ=5, and the LFSR tap constant in package quiz_pkg.
REQ-035 SHALL place the LFSR in sub-module lfsr16 (ports clk, reset, q[15:0]).

Verification
REQ-036 SHALL check: reset, start, then type the expected answer digits and enter -> one correct_pulse, score=1, round_idx=1.
REQ-037 SHALL check: TIME_LIMIT=3 with no input -> wrong_pulse on the 3rd frame_tick, score unchanged.
REQ-038 SHALL check: digits 4,2,7 -> entry=42 and entry_cnt=2; enter with entry_cnt==0 -> no state change.
REQ-039 SHALL check: NUM_ROUNDS=2 and FB_FRAMES=1 with both answers correct -> game_over=1 and score=2; start -> score=0 and busy=1.
REQ-040 SHALL check: 10,000 GEN acceptances -> every equation legal, answer 0..99, and no division remainder.
REQ-041 SHALL check: reset asserted in SHOW with entry=5 -> all outputs 0 and state IDLE before the next clk edge.
